// File: rtl/ft245_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding the FT245 host-transmit byte stream.
// Each grant emits a source-tagged header byte; bursts are capped at MAX_BURST bytes.
module ft245_tx_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int MAX_BURST = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*NUM_PORTS-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]   s_axis_tvalid,
    output logic [NUM_PORTS-1:0]   s_axis_tready,
    input  logic [NUM_PORTS-1:0]   s_axis_tlast,
    output logic [7:0]             m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   busy,
    output logic [1:0]             grant_id
);

    localparam int unsigned NP = NUM_PORTS;
    localparam int          CW = $clog2(MAX_BURST + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0]    state;
    logic [1:0]    last_grant;
    logic [CW-1:0] count;
    logic [CW-1:0] count_inc;
    logic [3:0]    cont_flag;

    logic          out_free;
    logic          any_valid;
    logic [1:0]    next_grant;
    logic          sel_valid;
    logic          sel_last;
    logic [7:0]    sel_data;
    logic          xfer;

    assign out_free  = !m_axis_tvalid || m_axis_tready;
    assign count_inc = count + 1'b1;
    assign xfer      = (state == ST_DATA) && sel_valid && out_free;

    // First valid port strictly after last_grant, wrapping modulo NUM_PORTS.
    always_comb begin
        any_valid  = 1'b0;
        next_grant = last_grant;
        for (int unsigned step = 1; step <= NP; step++) begin
            for (int unsigned p = 0; p < NP; p++) begin
                if (!any_valid && s_axis_tvalid[p] &&
                    p == (32'(last_grant) + step) % NP) begin
                    any_valid  = 1'b1;
                    next_grant = 2'(p);
                end
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int unsigned p = 0; p < NP; p++) begin
            if (grant_id == 2'(p)) begin
                sel_valid = s_axis_tvalid[p];
                sel_last  = s_axis_tlast[p];
                sel_data  = s_axis_tdata[8*p +: 8];
            end
        end
    end

    always_comb begin
        s_axis_tready = '0;
        for (int unsigned p = 0; p < NP; p++) begin
            s_axis_tready[p] = (state == ST_DATA) && (grant_id == 2'(p)) && out_free;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= 8'h00;
            grant_id      <= '0;
            last_grant    <= 2'(NUM_PORTS - 1);
            cont_flag     <= '0;
            count         <= '0;
            busy          <= 1'b0;
        end else begin
            // Accepted bytes retire here; any load below re-asserts valid.
            if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        grant_id   <= next_grant;
                        last_grant <= next_grant;
                        busy       <= 1'b1;
                        state      <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (out_free) begin
                        m_axis_tdata  <= {4'hA, cont_flag[grant_id], 1'b0, grant_id};
                        m_axis_tvalid <= 1'b1;
                        count         <= '0;
                        state         <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        m_axis_tdata  <= sel_data;
                        m_axis_tvalid <= 1'b1;
                        count         <= count_inc;
                        if (sel_last) begin
                            cont_flag[grant_id] <= 1'b0;
                            busy                <= 1'b0;
                            state               <= ST_IDLE;
                        end else if (count_inc == CW'(MAX_BURST)) begin
                            cont_flag[grant_id] <= 1'b1;
                            busy                <= 1'b0;
                            state               <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ft245_tx_arbiter.sv
// Bench for ft245_tx_arbiter: cycle-vector table for a single packet, then
// queue-driven sources with a byte scoreboard for arbitration corner cases.
module tb_ft245_tx_arbiter;

    localparam int NP = 2;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [8*NP-1:0] s_axis_tdata;
    logic [NP-1:0]   s_axis_tvalid;
    logic [NP-1:0]   s_axis_tready;
    logic [NP-1:0]   s_axis_tlast;
    logic [7:0]      m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic            busy;
    logic [1:0]      grant_id;

    always #5 clk = ~clk;

    ft245_tx_arbiter #(.NUM_PORTS(NP), .MAX_BURST(MB)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .grant_id      (grant_id)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]    exp_q[$];
    logic [8:0]    src_q[NP][$];
    logic [NP-1:0] stall;

    typedef struct {
        logic [1:0]  tvalid;
        logic [15:0] tdata;
        logic [1:0]  tlast;
        logic        mready;
        logic        exp_mvalid;
        logic [7:0]  exp_mdata;
        logic        exp_busy;
        logic [1:0]  exp_grant;
        logic [1:0]  exp_sready;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_src(input int p, input logic [7:0] b, input logic last);
        src_q[p].push_back({last, b});
    endtask

    task automatic push_exp(input logic [7:0] b);
        exp_q.push_back(b);
    endtask

    task automatic drive_sources();
        logic [8:0] h;
        for (int p = 0; p < NP; p++) begin
            if (src_q[p].size() > 0 && !stall[p]) begin
                h = src_q[p][0];
                s_axis_tvalid[p]        = 1'b1;
                s_axis_tdata[8*p +: 8] = h[7:0];
                s_axis_tlast[p]         = h[8];
            end else begin
                s_axis_tvalid[p]        = 1'b0;
                s_axis_tdata[8*p +: 8] = 8'h00;
                s_axis_tlast[p]         = 1'b0;
            end
        end
    endtask

    // Sample mid-cycle, retire handshakes, then advance sources after the edge.
    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_extra: got %0h expected none", m_axis_tdata);
            end else begin
                e = exp_q.pop_front();
                chk("sb_byte", 32'(m_axis_tdata), 32'(e));
            end
        end
        for (int p = 0; p < NP; p++) begin
            if (s_axis_tvalid[p] && s_axis_tready[p]) begin
                void'(src_q[p].pop_front());
            end
        end
        @(posedge clk);
        #1;
        drive_sources();
    endtask

    task automatic drain(input string name, input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        chk({name, "_left"}, 32'(exp_q.size()), 32'd0);
        repeat (4) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int p = 0; p < NP; p++) src_q[p].delete();
        exp_q.delete();
        stall         = '0;
        m_axis_tready = 1'b1;
        drive_sources();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b1;
        stall         = '0;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_mvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_mdata",  32'(m_axis_tdata),  32'h00);
        chk("rst_sready", 32'(s_axis_tready), 32'd0);
        chk("rst_busy",   32'(busy),          32'd0);
        chk("rst_grant",  32'(grant_id),      32'd0);
        @(posedge clk);
        #1;

        // Single packet on port 1, cycle by cycle: header in cycle 2, busy falls after 33
        vecs[0] = '{2'b10, 16'h1100, 2'b00, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 2'b00};
        vecs[1] = '{2'b10, 16'h1100, 2'b00, 1'b1, 1'b0, 8'h00, 1'b1, 2'd1, 2'b00};
        vecs[2] = '{2'b10, 16'h1100, 2'b00, 1'b1, 1'b1, 8'hA1, 1'b1, 2'd1, 2'b10};
        vecs[3] = '{2'b10, 16'h2200, 2'b00, 1'b1, 1'b1, 8'h11, 1'b1, 2'd1, 2'b10};
        vecs[4] = '{2'b10, 16'h3300, 2'b10, 1'b1, 1'b1, 8'h22, 1'b1, 2'd1, 2'b10};
        vecs[5] = '{2'b00, 16'h0000, 2'b00, 1'b1, 1'b1, 8'h33, 1'b0, 2'd1, 2'b00};
        vecs[6] = '{2'b00, 16'h0000, 2'b00, 1'b1, 1'b0, 8'h00, 1'b0, 2'd1, 2'b00};
        for (int i = 0; i < 7; i++) begin
            s_axis_tvalid = vecs[i].tvalid;
            s_axis_tdata  = vecs[i].tdata;
            s_axis_tlast  = vecs[i].tlast;
            m_axis_tready = vecs[i].mready;
            @(negedge clk);
            chk($sformatf("vec%0d_mvalid", i), 32'(m_axis_tvalid), 32'(vecs[i].exp_mvalid));
            if (vecs[i].exp_mvalid)
                chk($sformatf("vec%0d_mdata", i), 32'(m_axis_tdata), 32'(vecs[i].exp_mdata));
            chk($sformatf("vec%0d_busy", i),   32'(busy),          32'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_grant", i),  32'(grant_id),      32'(vecs[i].exp_grant));
            chk($sformatf("vec%0d_sready", i), 32'(s_axis_tready), 32'(vecs[i].exp_sready));
            @(posedge clk);
            #1;
        end

        // Round-robin: port 0 first, then 1, then port 0 again
        do_reset();
        push_src(0, 8'h10, 1'b0); push_src(0, 8'h11, 1'b1);
        push_src(0, 8'h12, 1'b0); push_src(0, 8'h13, 1'b1);
        push_src(1, 8'h20, 1'b0); push_src(1, 8'h21, 1'b1);
        push_exp(8'hA0); push_exp(8'h10); push_exp(8'h11);
        push_exp(8'hA1); push_exp(8'h20); push_exp(8'h21);
        push_exp(8'hA0); push_exp(8'h12); push_exp(8'h13);
        drive_sources();
        drain("rr", 200);

        // Burst cap: 6-byte packet cut after 4, resumed with continuation header
        do_reset();
        for (int b = 1; b <= 6; b++) push_src(0, 8'(b), b == 6);
        push_src(0, 8'h07, 1'b1);
        push_exp(8'hA0);
        for (int b = 1; b <= 4; b++) push_exp(8'(b));
        push_exp(8'hA8); push_exp(8'h05); push_exp(8'h06);
        push_exp(8'hA0); push_exp(8'h07);
        drive_sources();
        drain("cap", 200);

        // Backpressure mid-burst for 5 cycles
        do_reset();
        for (int b = 1; b <= 6; b++) push_src(0, 8'(8'h30 + b), b == 6);
        push_exp(8'hA0); push_exp(8'h31); push_exp(8'h32); push_exp(8'h33);
        push_exp(8'h34); push_exp(8'hA8); push_exp(8'h35); push_exp(8'h36);
        drive_sources();
        n = 0;
        while (exp_q.size() > 5 && n < 50) begin
            tick();
            n++;
        end
        chk("bp_reach", 32'(exp_q.size()), 32'd5);
        m_axis_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_mvalid", 32'(m_axis_tvalid), 32'd1);
            chk("bp_mdata",  32'(m_axis_tdata),  32'(exp_q[0]));
            chk("bp_sready", 32'(s_axis_tready), 32'd0);
            @(posedge clk);
            #1;
        end
        m_axis_tready = 1'b1;
        drain("bp", 200);

        // Requester stall: port 0 drops valid mid-packet while port 1 waits
        do_reset();
        push_src(0, 8'h41, 1'b0); push_src(0, 8'h42, 1'b0);
        push_src(0, 8'h43, 1'b0); push_src(0, 8'h44, 1'b1);
        push_src(1, 8'h51, 1'b0); push_src(1, 8'h52, 1'b1);
        push_exp(8'hA0); push_exp(8'h41); push_exp(8'h42); push_exp(8'h43);
        push_exp(8'h44); push_exp(8'hA1); push_exp(8'h51); push_exp(8'h52);
        drive_sources();
        n = 0;
        while (exp_q.size() > 6 && n < 50) begin
            tick();
            n++;
        end
        stall[0] = 1'b1;
        drive_sources();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_grant",   32'(grant_id),         32'd0);
            chk("stall_sready1", 32'(s_axis_tready[1]), 32'd0);
            chk("stall_busy",    32'(busy),             32'd1);
        end
        chk("stall_mvalid", 32'(m_axis_tvalid), 32'd0);
        stall[0] = 1'b0;
        drive_sources();
        drain("stall", 200);

        // Asynchronous reset during DATA, then fresh arbitration from port 0
        do_reset();
        for (int b = 1; b <= 4; b++) push_src(0, 8'(8'h60 + b), b == 4);
        push_exp(8'hA0); push_exp(8'h61);
        drive_sources();
        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            tick();
            n++;
        end
        #3;
        rst = 1'b1;
        #1;
        chk("arst_mvalid", 32'(m_axis_tvalid), 32'd0);
        chk("arst_sready", 32'(s_axis_tready), 32'd0);
        chk("arst_busy",   32'(busy),          32'd0);
        chk("arst_grant",  32'(grant_id),      32'd0);
        do_reset();
        push_src(0, 8'h71, 1'b1);
        push_src(1, 8'h81, 1'b1);
        push_exp(8'hA0); push_exp(8'h71); push_exp(8'hA1); push_exp(8'h81);
        drive_sources();
        drain("arst", 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
